// File: rtl/mc_seq_alu.sv
// Multi-cycle ALU: single-cycle add/sub/logic/mov; iterative radix-2 MUL/UMULL/SMULL/UDIV (and SDIV when MC_SEQ_ALU_SDIV_EN is defined).
// Latency: 1 cycle for single-cycle ops and divide-by-zero, WIDTH+1 cycles for multiply/divide; done is a one-cycle pulse.
// Backpressure: ready=1 only in IDLE; start while busy or in DONE is dropped, never queued.
module mc_seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result2,
    output logic [3:0]       alu_flags,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int MSB   = WIDTH - 1;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_MUL   = 4'b0100;
    localparam logic [3:0] OP_UMULL = 4'b0101;
    localparam logic [3:0] OP_SMULL = 4'b0110;
    localparam logic [3:0] OP_UDIV  = 4'b0111;
    localparam logic [3:0] OP_MOV   = 4'b1100;
`ifdef MC_SEQ_ALU_SDIV_EN
    localparam logic [3:0] OP_SDIV  = 4'b1101;
`endif

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [3:0]         op_q;
    logic               neg_q, neg_rem_q, ovf_q;

    logic               is_sdiv, is_div_op, is_mul_op, signed_op, b_zero, sdiv_ovf;
    logic [WIDTH-1:0]   abs_a, abs_b;

`ifdef MC_SEQ_ALU_SDIV_EN
    assign is_sdiv = (alu_control == OP_SDIV);
`else
    assign is_sdiv = 1'b0;
`endif
    assign is_div_op = (alu_control == OP_UDIV) || is_sdiv;
    assign is_mul_op = (alu_control == OP_MUL) || (alu_control == OP_UMULL) || (alu_control == OP_SMULL);
    assign signed_op = (alu_control == OP_SMULL) || is_sdiv;
    assign b_zero    = (b == '0);
    assign abs_a     = (signed_op && a[MSB]) ? -a : a;
    assign abs_b     = (signed_op && b[MSB]) ? -b : b;
    assign sdiv_ovf  = is_sdiv && (a == {1'b1, {MSB{1'b0}}}) && (b == '1);
    assign ready     = (state == S_IDLE);

    // Single-cycle datapath, evaluated on the accepting edge
    logic             sub_op;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_res, sc_res2;
    logic             sc_c, sc_v, sc_legal, sc_dbz;
    logic [3:0]       sc_flags;

    assign sub_op = (alu_control == OP_SUB);
    assign b_op   = sub_op ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub_op};

    always_comb begin
        sc_res   = '0;
        sc_res2  = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        sc_legal = 1'b1;
        sc_dbz   = 1'b0;
        case (alu_control)
            OP_ADD, OP_SUB: begin
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (a[MSB] == b_op[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_AND: sc_res = a & b;
            OP_OR:  sc_res = a | b;
            OP_MOV: sc_res = b;
            default: begin
                if (is_div_op) begin
                    sc_res  = '1;
                    sc_res2 = a;
                    sc_dbz  = 1'b1;
                end else begin
                    sc_legal = 1'b0;
                end
            end
        endcase
        sc_flags = sc_legal ? {sc_res[MSB], sc_res == '0, sc_c, sc_v} : 4'b0000;
    end

    // One radix-2 step: shift-add for multiply ({hi, multiplier}), restoring for divide ({rem, dividend})
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0] mul_nxt, div_nxt;
    logic               div_ge;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_nxt  = {mul_sum, acc[WIDTH-1:1]};
    assign div_sh   = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_sh - {1'b0, opnd};
    assign div_ge   = ~div_diff[WIDTH];
    assign div_nxt  = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, fin_res, fin_res2;
    logic               fin_long;
    logic [3:0]         fin_flags;

    always_comb begin
        prod     = neg_q ? -mul_nxt : mul_nxt;
        quo      = neg_q ? -div_nxt[WIDTH-1:0] : div_nxt[WIDTH-1:0];
        rem      = neg_rem_q ? -div_nxt[2*WIDTH-1:WIDTH] : div_nxt[2*WIDTH-1:WIDTH];
        fin_res  = prod[2*WIDTH-1:WIDTH];
        fin_res2 = prod[WIDTH-1:0];
        fin_long = 1'b1;
        if (state == S_DIV) begin
            fin_res  = quo;
            fin_res2 = rem;
            fin_long = 1'b0;
        end else if (op_q == OP_MUL) begin
            fin_res  = prod[WIDTH-1:0];
            fin_res2 = '0;
        end
        fin_flags = {fin_res[MSB], (fin_res == '0) && (!fin_long || fin_res2 == '0),
                     1'b0, (state == S_DIV) && ovf_q};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            neg_rem_q   <= 1'b0;
            ovf_q       <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            result2     <= '0;
            alu_flags   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    op_q      <= alu_control;
                    cnt       <= '0;
                    neg_q     <= signed_op && (a[MSB] ^ b[MSB]);
                    neg_rem_q <= is_sdiv && a[MSB];
                    ovf_q     <= sdiv_ovf;
                    if (is_mul_op) begin
                        acc   <= {{WIDTH{1'b0}}, abs_b};
                        opnd  <= abs_a;
                        state <= S_MUL;
                    end else if (is_div_op && !b_zero) begin
                        acc   <= {{WIDTH{1'b0}}, abs_a};
                        opnd  <= abs_b;
                        state <= S_DIV;
                    end else begin
                        state       <= S_DONE;
                        done        <= 1'b1;
                        result      <= sc_res;
                        result2     <= sc_res2;
                        alu_flags   <= sc_flags;
                        div_by_zero <= sc_dbz;
                    end
                end
                S_MUL, S_DIV: begin
                    acc <= (state == S_MUL) ? mul_nxt : div_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state       <= S_DONE;
                        done        <= 1'b1;
                        result      <= fin_res;
                        result2     <= fin_res2;
                        alu_flags   <= fin_flags;
                        div_by_zero <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_seq_alu.sv
// Randomized and directed bench for mc_seq_alu against a plain-arithmetic reference model.
module tb_mc_seq_alu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [3:0]   alu_control;
    logic [W-1:0] a, b;
    logic         ready, done;
    logic [W-1:0] result, result2;
    logic [3:0]   alu_flags;
    logic         div_by_zero;

    int vectors = 0;
    int miscompares = 0;

    mc_seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .alu_control(alu_control),
        .a(a), .b(b), .ready(ready), .done(done), .result(result),
        .result2(result2), .alu_flags(alu_flags), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference model: 64-bit arithmetic straight from the opcode definitions
    task automatic model(input logic [3:0] op, input logic [W-1:0] oa, ob,
                         output logic [W-1:0] r, r2, output logic [3:0] fl,
                         output logic dz, output int lat);
        logic [63:0] p;
        longint      s;
        logic        c, v;
        r = '0; r2 = '0; fl = 4'b0; dz = 1'b0; lat = 1; c = 1'b0; v = 1'b0;
        case (op)
            4'd0, 4'd1: begin
                if (op == 4'd0) begin
                    p = {32'd0, oa} + {32'd0, ob};
                    c = p[32];
                    s = longint'($signed(oa)) + longint'($signed(ob));
                end else begin
                    p = {32'd0, oa} - {32'd0, ob};
                    c = (oa >= ob);
                    s = longint'($signed(oa)) - longint'($signed(ob));
                end
                r  = p[31:0];
                v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                fl = {r[31], r == 0, c, v};
            end
            4'd2, 4'd3, 4'd12: begin
                r  = (op == 4'd2) ? (oa & ob) : (op == 4'd3) ? (oa | ob) : ob;
                fl = {r[31], r == 0, 2'b00};
            end
            4'd4, 4'd5, 4'd6: begin
                if (op == 4'd6) p = longint'($signed(oa)) * longint'($signed(ob));
                else            p = {32'd0, oa} * {32'd0, ob};
                lat = W + 1;
                if (op == 4'd4) r = p[31:0];
                else begin r = p[63:32]; r2 = p[31:0]; end
                fl = {r[31], (r == 0) && (r2 == 0), 2'b00};
            end
            4'd7: begin
                if (ob == 0) begin r = '1; r2 = oa; dz = 1'b1; end
                else begin r = oa / ob; r2 = oa % ob; lat = W + 1; end
                fl = {r[31], r == 0, 2'b00};
            end
`ifdef MC_SEQ_ALU_SDIV_EN
            4'd13: begin
                if (ob == 0) begin r = '1; r2 = oa; dz = 1'b1; end
                else begin
                    p  = longint'($signed(oa)) / longint'($signed(ob));
                    r  = p[31:0];
                    p  = longint'($signed(oa)) % longint'($signed(ob));
                    r2 = p[31:0];
                    lat = W + 1;
                    v  = (oa == 32'h8000_0000) && (ob == 32'hFFFF_FFFF);
                end
                fl = {r[31], r == 0, 1'b0, v};
            end
`endif
            default: ;
        endcase
    endtask

    // Waits for ready, issues one op, scrambles inputs after acceptance, waits for done
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] oa, ob,
                         output int lat, output logic [W-1:0] r, r2,
                         output logic [3:0] fl, output logic dz);
        int guard = 0;
        @(negedge clk);
        while (!ready && guard < 100) begin @(negedge clk); guard++; end
        start = 1'b1; alu_control = op; a = oa; b = ob;
        @(posedge clk); #1;
        start = 1'b0; alu_control = 4'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!done) lat = -1;
        r = result; r2 = result2; fl = alu_flags; dz = div_by_zero;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; alu_control = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({ready, done, result, result2, alu_flags, div_by_zero} !== {1'b1, 1'b0, 64'd0, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: ready=%b done=%b res=%h res2=%h fl=%b dz=%b want ready=1 rest 0",
                     ready, done, result, result2, alu_flags, div_by_zero);
        end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic check_op(input string tag, input logic [3:0] op, input logic [W-1:0] oa, ob);
        logic [W-1:0] er, er2, r, r2;
        logic [3:0]   efl, fl;
        logic         edz, dz;
        int           elat, lat;
        model(op, oa, ob, er, er2, efl, edz, elat);
        do_op(op, oa, ob, lat, r, r2, fl, dz);
        vectors++;
        if (lat !== elat) begin
            miscompares++;
            $display("FAIL %s op=%h latency: got %0d want %0d", tag, op, lat, elat);
        end
        vectors++;
        if ({r, r2} !== {er, er2}) begin
            miscompares++;
            $display("FAIL %s op=%h a=%h b=%h result: got %h/%h want %h/%h", tag, op, oa, ob, r, r2, er, er2);
        end
        vectors++;
        if ({fl, dz} !== {efl, edz}) begin
            miscompares++;
            $display("FAIL %s op=%h a=%h b=%h flags/dz: got %b/%b want %b/%b", tag, op, oa, ob, fl, dz, efl, edz);
        end
        @(posedge clk); #1;
        vectors++;
        if ({done, ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL %s op=%h after_done: done=%b ready=%b want done=0 ready=1", tag, op, done, ready);
        end
    endtask

    task automatic test_directed();
        logic [3:0]   ops[9] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd7, 4'd12, 4'd14};
        logic [W-1:0] as[9]  = '{32'h7FFF_FFFF, 32'd5, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                                 32'd100, 32'd100, 32'd0, 32'h1234_5678};
        logic [W-1:0] bs[9]  = '{32'd1, 32'd5, 32'hFF00_FF00, 32'hFFFF_FFFF, 32'd3,
                                 32'd7, 32'd0, 32'hDEAD_BEEF, 32'h9ABC_DEF0};
        for (int i = 0; i < 9; i++) check_op("directed", ops[i], as[i], bs[i]);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) check_op("random", 4'($urandom_range(0, 15)), pick(), pick());
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] er, er2, cr, cr2;
        logic [3:0]   efl;
        logic         edz;
        int           elat, ndone = 0, done_cyc = -1, rdy33 = -1, rdy34 = -1;
        model(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, er, er2, efl, edz, elat);
        @(negedge clk);
        start = 1'b1; alu_control = 4'd5; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == 9);
            alu_control = (cyc == 9) ? 4'd0 : alu_control;
            if (cyc == 9) begin a = 32'd1; b = 32'd2; end
            if (done) begin ndone++; done_cyc = cyc; cr = result; cr2 = result2; end
            if (cyc == 33) rdy33 = int'(ready);
            if (cyc == 34) rdy34 = int'(ready);
        end
        start = 1'b0;
        vectors++;
        if (ndone != 1 || done_cyc != 33) begin
            miscompares++;
            $display("FAIL ignore_start done: count=%0d at cycle %0d want 1 at 33", ndone, done_cyc);
        end
        vectors++;
        if ({cr, cr2} !== {er, er2}) begin
            miscompares++;
            $display("FAIL ignore_start result: got %h/%h want %h/%h", cr, cr2, er, er2);
        end
        vectors++;
        if (rdy33 != 0 || rdy34 != 1) begin
            miscompares++;
            $display("FAIL ignore_start ready: cycle33=%0d cycle34=%0d want 0 then 1", rdy33, rdy34);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] r, r2;
        logic [3:0]   fl;
        logic         dz;
        int           lat, spurious = 0;
        do_op(4'd12, 32'd0, 32'hDEAD_BEEF, lat, r, r2, fl, dz);
        @(negedge clk);
        while (!ready) @(negedge clk);
        start = 1'b1; alu_control = 4'd7; a = $urandom; b = 32'($urandom_range(1, 1000));
        for (int cyc = 1; cyc < 15; cyc++) begin @(posedge clk); #1; start = 1'b0; end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        vectors++;
        if ({ready, done, result, result2, alu_flags, div_by_zero} !== {1'b1, 1'b0, 64'd0, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid outputs: ready=%b done=%b res=%h res2=%h fl=%b dz=%b want ready=1 rest 0",
                     ready, done, result, result2, alu_flags, div_by_zero);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin @(posedge clk); #1; if (done) spurious++; end
        vectors++;
        if (spurious != 0) begin
            miscompares++;
            $display("FAIL reset_mid no_done: got %0d done pulses want 0", spurious);
        end
        check_op("reset_mid_add", 4'd0, 32'd2, 32'd3);
        vectors++;
        if (result !== 32'd5) begin
            miscompares++;
            $display("FAIL reset_mid add_result: got %h want 00000005", result);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mc_seq_alu.md
Name: mc_seq_alu

Overview:
Parametrised, multi-cycle successor to the datapath's combinational ALU. It keeps the single-cycle add/sub/logic/mov operations and moves MUL/UMULL/SMULL/UDIV onto an iterative radix-2 engine with a start/done handshake, so a wide divider or multiplier no longer sits on the critical path. It sits in the execute stage and is driven by the multi-cycle controller, which holds its FSM in an execute state until done.

Parameters:
WIDTH, 32, operand/result width in bits; supported range 8..64.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request; accepted only while ready=1
alu_control  in  4  opcode, sampled with start
a  in  WIDTH  operand A, sampled with start
b  in  WIDTH  operand B, sampled with start
ready  out  1  1 in IDLE only
done  out  1  one-cycle pulse; result, result2, alu_flags, div_by_zero valid
result  out  WIDTH  main result; high half for UMULL/SMULL; quotient for UDIV
result2  out  WIDTH  low half for UMULL/SMULL; remainder for UDIV; 0 otherwise
alu_flags  out  4  {N,Z,C,V}
div_by_zero  out  1  set with done when UDIV/SDIV had b=0

Behaviour:
- Opcodes: 0000 ADD, 0001 SUB (a+~b+1), 0010 AND, 0011 OR, 0100 MUL (low WIDTH bits), 0101 UMULL, 0110 SMULL, 0111 UDIV, 1100 MOV (result=b), 1101 SDIV (optional feature). Any other opcode completes as single-cycle with result=0, result2=0, flags=0000.
- Reset (reset=0, any time, including mid-operation): state=IDLE; ready=1; done=0; result, result2, alu_flags, div_by_zero all 0; counter and internal accumulators cleared. An in-flight operation is discarded with no done.
- FSM: IDLE -> (start, single-cycle op or divide-by-zero) -> DONE; IDLE -> (start, multiply op) -> MUL; IDLE -> (start, UDIV/SDIV, b!=0) -> DIV; MUL/DIV -> (counter reaches WIDTH-1) -> DONE; DONE -> IDLE, unconditionally.
- Operands and opcode are latched on acceptance. Input changes after acceptance have no effect.
- Latency from the accepting edge: single-cycle ops raise done on the next edge (1 cycle). MUL/UMULL/SMULL/UDIV/SDIV raise done after WIDTH+1 cycles; WIDTH=32 gives 33.
- start while ready=0 is ignored, with no queuing. start in DONE is also ignored, because ready=0 in DONE.
- Outputs register at the DONE transition and hold until the next DONE or reset. done is high for exactly 1 cycle.
- Multiply: shift-add over |a|,|b| in a 2*WIDTH accumulator. SMULL negates the product when a[MSB]^b[MSB] is set. MUL returns the low half in result; result2=0.
- UDIV: restoring divide, one quotient bit per cycle. For b=0: result = all ones, result2 = a, div_by_zero=1, latency 1.
- Flags: N=result[WIDTH-1]. Z=(result==0), and for UMULL/SMULL also requires result2==0. C = carry out of the WIDTH-bit adder for ADD/SUB (SUB: C=1 means no borrow), 0 otherwise. V = signed overflow for ADD/SUB, 0 otherwise.

Optional Feature:
MC_SEQ_ALU_SDIV_EN. When defined, opcode 1101 performs signed divide: the quotient is truncated toward zero and the remainder takes the sign of a. Most-negative / -1 gives result = most-negative, result2 = 0, V=1. b=0 is handled as for UDIV. When not defined, 1101 is treated as an illegal opcode (single-cycle, zero outputs).

Test Plan:
- ADD a=0x7FFFFFFF, b=1 -> done 1 cycle after start; result 0x80000000, flags N1 Z0 C0 V1.
- SUB a=5, b=5 -> result 0, flags 0110; then AND 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000, flags 1000.
- UMULL a=b=0xFFFFFFFF -> done at cycle 33; result 0xFFFFFFFE, result2 0x00000001. SMULL a=0xFFFFFFFE (-2), b=3 -> result 0xFFFFFFFF, result2 0xFFFFFFFA, N=1, Z=0.
- UDIV 100/7 -> done at cycle 33; result 14, result2 2, div_by_zero 0. UDIV 100/0 -> done at cycle 1; result 0xFFFFFFFF, result2 100, div_by_zero 1.
- UMULL in flight; start pulsed with ADD at cycle 10 -> ignored, with exactly one done at cycle 33 carrying the UMULL result; ready returns high at cycle 34.
- reset=0 at cycle 15 of UDIV -> all outputs 0 immediately, ready=1, no done. A new ADD 2+3 after release -> result 5 after 1 cycle.
